fetch_unit: RTL and testbench

- Parametrised successor to the single-cycle program counter and instruction memory path.
- Generates fetch addresses, issues requests to an instruction memory with variable latency over a req/gnt/rvalid handshake, and buffers returned instructions in a DEPTH-entry prefetch FIFO.
- Presents the buffered instructions, each with its PC, to the decoder.
- Resolves branch and jump redirects with a buffer flush. Supports halt.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_buffer.sv | 63 ++++++
 rtl/fetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_unit.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and default parameters for the fetch unit
package fetch_pkg;

  localparam int DEF_INSTR_W   = 16;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_BR_IMM_W  = 6;
  localparam int DEF_JMP_IMM_W = 12;
  localparam int DEF_RESET_PC  = 0;

  // RUN: may issue; WAIT_RSP: granted, awaiting data;
  // DROP_RSP: finishing a request whose data is stale; HALTED: until reset.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_RSP = 2'd1,
    DROP_RSP = 2'd2,
    HALTED   = 2'd3
  } fetch_state_e;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - circular prefetch FIFO with flush
module fetch_buffer #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush discards everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({do_push, do_pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Storage array; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (en && do_push && !flush) mem[wr_ptr] <= wdata;
  end

  overflow_check: assert property (@(posedge clk) disable iff (!rst_n) (en && push) |-> !full);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch FSM, PC and redirect logic in front of the prefetch buffer
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int INSTR_W   = DEF_INSTR_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int BR_IMM_W  = DEF_BR_IMM_W,
  parameter int JMP_IMM_W = DEF_JMP_IMM_W,
  parameter int RESET_PC  = DEF_RESET_PC
) (
  input  logic                 clk_pi,
  input  logic                 reset_n_pi,
  input  logic                 clk_en_pi,
  output logic                 imem_req_po,
  output logic [ADDR_W-1:0]    imem_addr_po,
  input  logic                 imem_gnt_pi,
  input  logic                 imem_rvalid_pi,
  input  logic [INSTR_W-1:0]   imem_rdata_pi,
  output logic                 instr_valid_po,
  output logic [INSTR_W-1:0]   instr_po,
  output logic [ADDR_W-1:0]    instr_pc_po,
  input  logic                 instr_ready_pi,
  input  logic                 branch_taken_pi,
  input  logic [BR_IMM_W-1:0]  branch_immediate_pi,
  input  logic                 jump_taken_pi,
  input  logic [JMP_IMM_W-1:0] jump_immediate_pi,
  input  logic                 halt_pi,
  output logic                 halted_po
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int BUF_W = INSTR_W + ADDR_W;

  fetch_state_e      state;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] fetch_pc;

  logic [BUF_W-1:0]  head;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              head_valid;
  logic              consume;
  logic              halt_ev;
  logic              redirect;
  logic              push;
  logic              room_after_rsp;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] jmp_off;
  logic [ADDR_W-1:0] target;

  // Head is hidden once halted so the decoder never sees leftover entries.
  assign head_valid     = ~empty & (state != HALTED);
  assign instr_valid_po = head_valid;
  assign instr_po       = head_valid ? head[BUF_W-1:ADDR_W] : '0;
  assign instr_pc_po    = head_valid ? head[ADDR_W-1:0] : '0;
  assign imem_req_po    = req_q;
  assign imem_addr_po   = addr_q;
  assign halted_po      = (state == HALTED);

  assign consume  = head_valid & instr_ready_pi;
  assign halt_ev  = consume & halt_pi;
  assign redirect = consume & (branch_taken_pi | jump_taken_pi) & ~halt_pi;

  // Offsets are sign-extended; the sum wraps naturally at ADDR_W bits.
  assign br_off  = ADDR_W'($signed(branch_immediate_pi));
  assign jmp_off = ADDR_W'($signed(jump_immediate_pi));
  assign target  = instr_pc_po + ADDR_W'(1) + (jump_taken_pi ? jmp_off : br_off);

  // A response is only kept while in WAIT_RSP; flush overrides it inside the buffer.
  assign push = (state == WAIT_RSP) & imem_rvalid_pi;

  // Space for one more fetch once the current response has landed.
  assign room_after_rsp = consume | (count < CNT_W'(DEPTH - 1));

  fetch_buffer #(
    .WIDTH (BUF_W),
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk   (clk_pi),
    .rst_n (reset_n_pi),
    .en    (clk_en_pi),
    .flush (redirect | halt_ev),
    .push  (push),
    .wdata ({imem_rdata_pi, addr_q}),
    .pop   (consume),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Fetch sequencing: one outstanding request, redirects drain any stale response.
  always_ff @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      state    <= RUN;
      req_q    <= 1'b0;
      addr_q   <= '0;
      fetch_pc <= ADDR_W'(RESET_PC);
    end else if (clk_en_pi) begin
      case (state)
        RUN: begin
          if (halt_ev) begin
            state <= HALTED;
            req_q <= 1'b0;
          end else if (redirect) begin
            fetch_pc <= target;
            if (req_q) begin
              state <= DROP_RSP;
              if (imem_gnt_pi) req_q <= 1'b0;
            end
          end else if (req_q) begin
            if (imem_gnt_pi) begin
              req_q    <= 1'b0;
              fetch_pc <= fetch_pc + ADDR_W'(1);
              state    <= WAIT_RSP;
            end
          end else if (!full) begin
            req_q  <= 1'b1;
            addr_q <= fetch_pc;
          end
        end
        WAIT_RSP: begin
          if (halt_ev) begin
            state <= HALTED;
          end else if (redirect) begin
            fetch_pc <= target;
            state    <= imem_rvalid_pi ? RUN : DROP_RSP;
          end else if (imem_rvalid_pi) begin
            state <= RUN;
            if (room_after_rsp) begin
              req_q  <= 1'b1;
              addr_q <= fetch_pc;
            end
          end
        end
        DROP_RSP: begin
          if (req_q) begin
            if (imem_gnt_pi) req_q <= 1'b0;
          end else if (imem_rvalid_pi) begin
            state <= RUN;
          end
        end
        HALTED: begin
          req_q <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk_pi = 1'b0;
  logic        reset_n_pi;
  logic        clk_en_pi;
  logic        imem_req_po;
  logic [15:0] imem_addr_po;
  logic        imem_gnt_pi;
  logic        imem_rvalid_pi;
  logic [15:0] imem_rdata_pi;
  logic        instr_valid_po;
  logic [15:0] instr_po;
  logic [15:0] instr_pc_po;
  logic        instr_ready_pi;
  logic        branch_taken_pi;
  logic [5:0]  branch_immediate_pi;
  logic        jump_taken_pi;
  logic [11:0] jump_immediate_pi;
  logic        halt_pi;
  logic        halted_po;

  fetch_unit dut (
    .clk_pi              (clk_pi),
    .reset_n_pi          (reset_n_pi),
    .clk_en_pi           (clk_en_pi),
    .imem_req_po         (imem_req_po),
    .imem_addr_po        (imem_addr_po),
    .imem_gnt_pi         (imem_gnt_pi),
    .imem_rvalid_pi      (imem_rvalid_pi),
    .imem_rdata_pi       (imem_rdata_pi),
    .instr_valid_po      (instr_valid_po),
    .instr_po            (instr_po),
    .instr_pc_po         (instr_pc_po),
    .instr_ready_pi      (instr_ready_pi),
    .branch_taken_pi     (branch_taken_pi),
    .branch_immediate_pi (branch_immediate_pi),
    .jump_taken_pi       (jump_taken_pi),
    .jump_immediate_pi   (jump_immediate_pi),
    .halt_pi             (halt_pi),
    .halted_po           (halted_po)
  );

  always #5 clk_pi = ~clk_pi;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Instruction memory model: rdata = address, latency rsp_lat after grant.
  bit          gnt_en = 1'b1;
  bit          rand_gnt = 1'b0;
  bit          inject_rv = 1'b0;
  int          rsp_lat = 1;
  bit          pend = 1'b0;
  int          wait_cnt = 0;
  int          grant_count = 0;
  logic [15:0] pend_addr = '0;
  logic [15:0] cap_addr = '0;

  always @(negedge clk_pi) begin
    cap_addr       = imem_addr_po;
    imem_gnt_pi    = imem_req_po && gnt_en && !pend && (!rand_gnt || ($urandom_range(0, 1) == 1));
    imem_rvalid_pi = (pend && wait_cnt == 0) || inject_rv;
    imem_rdata_pi  = pend ? pend_addr : 16'hBAD0;
  end

  always @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      pend     = 1'b0;
      wait_cnt = 0;
    end else if (clk_en_pi) begin
      if (pend && wait_cnt == 0 && imem_rvalid_pi) pend = 1'b0;
      else if (pend && wait_cnt > 0) wait_cnt--;
      if (imem_gnt_pi) begin
        pend      = 1'b1;
        pend_addr = cap_addr;
        wait_cnt  = rsp_lat - 1;
        grant_count++;
      end
    end
  end

  // Scoreboard: every consumed head is checked against the expected queue.
  fetch_entry_t exp_q[$];
  fetch_entry_t e;

  always @(negedge clk_pi) begin
    #2;
    if (reset_n_pi && clk_en_pi && instr_valid_po && instr_ready_pi) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got pc %0h expected none", instr_pc_po);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", 32'(instr_pc_po), 32'(e.pc));
        check("sb_instr", 32'(instr_po), 32'(e.instr));
      end
    end
  end

  task automatic push_exp(input logic [15:0] pc);
    exp_q.push_back(fetch_entry_t'{instr: pc, pc: pc});
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) push_exp(16'(i));
  endtask

  task automatic step();
    @(negedge clk_pi);
    #1;
  endtask

  task automatic clear_ctl();
    instr_ready_pi  = 1'b0;
    branch_taken_pi = 1'b0;
    jump_taken_pi   = 1'b0;
    halt_pi         = 1'b0;
  endtask

  task automatic do_reset();
    reset_n_pi = 1'b0;
    clear_ctl();
    step();
    step();
    exp_q.delete();
    grant_count = 0;
    reset_n_pi = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!instr_valid_po && k < 200) begin
      step();
      k++;
    end
    if (!instr_valid_po) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: instr_valid stayed 0, required 1", name);
    end
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      instr_ready_pi = 1'b1;
      step();
      k++;
    end
    instr_ready_pi = 1'b0;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    bit          cons;
    bit          br;
    bit          jmp;
    bit          hlt;
    logic [5:0]  bimm;
    logic [11:0] jimm;
    logic [15:0] head_pc;
  } redir_t;

  redir_t tbl[9];

  initial begin
    bit          found;
    bit          seen;
    int          k;
    logic [15:0] s_addr;
    logic [15:0] s_pc;
    logic        s_req;
    logic        s_valid;

    // Redirect vectors; the head of each row is the target of the row before.
    tbl[0] = '{1, 0, 1, 0, 6'h00, 12'hFFD, 16'h0000};  // 0+1-3      -> FFFE
    tbl[1] = '{1, 0, 1, 0, 6'h00, 12'h003, 16'hFFFE};  // wraps      -> 0002
    tbl[2] = '{1, 1, 0, 0, 6'h3E, 12'h000, 16'h0002};  // 2+1-2      -> 0001
    tbl[3] = '{1, 1, 0, 0, 6'h1F, 12'h000, 16'h0001};  // 1+1+31     -> 0021
    tbl[4] = '{1, 1, 1, 0, 6'h01, 12'h7FF, 16'h0021};  // jump wins  -> 0821
    tbl[5] = '{1, 1, 0, 0, 6'h20, 12'h000, 16'h0821};  // -32        -> 0802
    tbl[6] = '{1, 0, 1, 0, 6'h00, 12'h800, 16'h0802};  // -2048      -> 0003
    tbl[7] = '{0, 1, 1, 1, 6'h05, 12'h005, 16'h0003};  // no consume -> 0003
    tbl[8] = '{1, 0, 0, 0, 6'h00, 12'h000, 16'h0003};  // plain      -> 0004

    clk_en_pi           = 1'b1;
    branch_immediate_pi = '0;
    jump_immediate_pi   = '0;
    reset_n_pi          = 1'b0;
    clear_ctl();
    step();
    step();

    // Reset values
    check("rst_req", 32'(imem_req_po), 32'd0);
    check("rst_addr", 32'(imem_addr_po), 32'd0);
    check("rst_valid", 32'(instr_valid_po), 32'd0);
    check("rst_instr", 32'(instr_po), 32'd0);
    check("rst_pc", 32'(instr_pc_po), 32'd0);
    check("rst_halted", 32'(halted_po), 32'd0);

    // Streaming
    reset_n_pi = 1'b1;
    step();
    check("first_req", 32'(imem_req_po), 32'd1);
    check("first_addr", 32'(imem_addr_po), 32'd0);
    push_range(0, 7);
    drain("stream_drain");

    // Backpressure and full
    do_reset();
    repeat (20) step();
    check("bp_grants", 32'(grant_count), 32'd4);
    check("bp_req_low", 32'(imem_req_po), 32'd0);
    check("bp_head_pc", 32'(instr_pc_po), 32'd0);
    push_range(0, 5);
    drain("bp_drain");

    // Taken branch from PC 5 with a request in WAIT_RSP
    do_reset();
    rsp_lat = 3;
    push_range(0, 5);
    found = 1'b0;
    k = 0;
    while (!found && k < 300) begin
      if (instr_valid_po && instr_pc_po == 16'd5 && pend) begin
        found               = 1'b1;
        instr_ready_pi      = 1'b1;
        branch_taken_pi     = 1'b1;
        branch_immediate_pi = 6'h3E;
      end else begin
        instr_ready_pi = instr_valid_po && (instr_pc_po < 16'd5);
      end
      step();
      k++;
    end
    clear_ctl();
    check("br_found", 32'(found), 32'd1);
    push_range(4, 6);
    drain("br_drain");

    // Redirect table with randomised grant timing
    do_reset();
    rsp_lat  = 2;
    rand_gnt = 1'b1;
    foreach (tbl[r]) begin
      wait_valid("tbl_wait");
      check("tbl_head_pc", 32'(instr_pc_po), 32'(tbl[r].head_pc));
      if (tbl[r].cons) push_exp(tbl[r].head_pc);
      instr_ready_pi      = tbl[r].cons;
      branch_taken_pi     = tbl[r].br;
      jump_taken_pi       = tbl[r].jmp;
      halt_pi             = tbl[r].hlt;
      branch_immediate_pi = tbl[r].bimm;
      jump_immediate_pi   = tbl[r].jimm;
      step();
      clear_ctl();
    end
    wait_valid("tbl_final_wait");
    check("tbl_final_pc", 32'(instr_pc_po), 32'h0004);
    check("tbl_sb_empty", 32'(exp_q.size()), 32'd0);
    rand_gnt = 1'b0;

    // Halt while a response is pending
    do_reset();
    rsp_lat = 3;
    push_range(0, 4);
    found = 1'b0;
    k = 0;
    while (!found && k < 300) begin
      if (instr_valid_po && instr_pc_po == 16'd4 && pend) begin
        found          = 1'b1;
        instr_ready_pi = 1'b1;
        halt_pi        = 1'b1;
      end else begin
        instr_ready_pi = instr_valid_po && (instr_pc_po < 16'd4);
      end
      step();
      k++;
    end
    clear_ctl();
    check("halt_found", 32'(found), 32'd1);
    check("halt_halted", 32'(halted_po), 32'd1);
    check("halt_valid", 32'(instr_valid_po), 32'd0);
    seen = 1'b0;
    repeat (10) begin
      step();
      if (imem_req_po || instr_valid_po || !halted_po) seen = 1'b1;
    end
    check("halt_quiet", 32'(seen), 32'd0);
    reset_n_pi = 1'b0;
    step();
    exp_q.delete();
    reset_n_pi = 1'b1;
    check("halt_cleared", 32'(halted_po), 32'd0);
    step();
    check("restart_req", 32'(imem_req_po), 32'd1);
    check("restart_addr", 32'(imem_addr_po), 32'd0);
    rsp_lat = 1;
    push_range(0, 2);
    drain("restart_drain");

    // Clock enable freeze, then asynchronous reset between edges
    do_reset();
    push_range(0, 19);
    instr_ready_pi = 1'b1;
    repeat (8) step();
    clk_en_pi = 1'b0;
    s_req   = imem_req_po;
    s_addr  = imem_addr_po;
    s_valid = instr_valid_po;
    s_pc    = instr_pc_po;
    seen    = 1'b0;
    repeat (5) begin
      step();
      if (imem_req_po !== s_req || imem_addr_po !== s_addr ||
          instr_valid_po !== s_valid || instr_pc_po !== s_pc) seen = 1'b1;
    end
    check("freeze_stable", 32'(seen), 32'd0);
    clk_en_pi = 1'b1;
    drain("freeze_drain");
    repeat (12) step();
    check("pre_reset_valid", 32'(instr_valid_po), 32'd1);
    @(posedge clk_pi);
    #3;
    reset_n_pi = 1'b0;
    #1;
    check("async_req", 32'(imem_req_po), 32'd0);
    check("async_addr", 32'(imem_addr_po), 32'd0);
    check("async_valid", 32'(instr_valid_po), 32'd0);
    check("async_instr", 32'(instr_po), 32'd0);
    check("async_pc", 32'(instr_pc_po), 32'd0);
    check("async_halted", 32'(halted_po), 32'd0);
    step();
    exp_q.delete();

    // Stray responses before the first granted request are ignored
    gnt_en     = 1'b0;
    reset_n_pi = 1'b1;
    inject_rv  = 1'b1;
    repeat (3) step();
    inject_rv = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      step();
      if (instr_valid_po) seen = 1'b1;
    end
    check("stray_ignored", 32'(seen), 32'd0);
    check("stray_req_addr", 32'(imem_addr_po), 32'd0);
    gnt_en = 1'b1;
    push_range(0, 1);
    drain("stray_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
